// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty sequencing blocks.
//   ramp_state_t : duty_ramp_ctrl FSM state encoding
//   DUTY_W       : width of the PWM duty word
//   DUTY_MAX     : largest representable duty
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN,
        SOFT_STOP
    } ramp_state_t;

    localparam int unsigned DUTY_W   = 4;
    localparam logic [3:0]  DUTY_MAX = 4'd15;

endpackage

// File: rtl/step_tick_gen.sv
// Free-running divide-by-DIV counter producing a single-cycle step tick.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   clr  : synchronous restart of the count at 0
//   tick : high for one cycle while the count equals DIV-1
module step_tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned      CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/duty_ramp_ctrl.sv
// Soft-start / soft-stop duty sequencer feeding the PWM stage. Moves duty one
// LSB per step tick toward an accepted target; a level stop ramps it to 0.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   target     : requested duty 0..15
//   load_valid : target valid this cycle
//   load_ready : block can accept a target (IDLE and no stop)
//   stop       : level soft-stop request
//   duty       : registered duty to the PWM stage
//   busy       : ramp or soft-stop in progress
//   done       : one-cycle pulse when duty reaches its goal
module duty_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned STEP_FREQ = 1_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] target,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic              stop,
    output logic [DUTY_W-1:0] duty,
    output logic              busy,
    output logic              done
);

    localparam int unsigned DIV = CLK_FREQ / STEP_FREQ;

    ramp_state_t       state;
    logic [DUTY_W-1:0] goal_q;
    logic [DUTY_W-1:0] duty_inc;
    logic [DUTY_W-1:0] duty_dec;
    logic              tick;
    logic              accept;
    logic              enter_stop;

    assign load_ready = (state == IDLE) && !stop;
    assign busy       = (state != IDLE);
    assign accept     = load_valid && load_ready;
    // A soft-stop in progress is never restarted, so a held stop does not
    // keep clearing the step counter.
    assign enter_stop = stop && (duty != '0) && (state != SOFT_STOP);
    assign duty_inc   = duty + DUTY_W'(1);
    assign duty_dec   = duty - DUTY_W'(1);

    // Restarting the divider on load and on soft-stop entry puts the first
    // step exactly DIV cycles after the triggering edge.
    step_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (accept || enter_stop),
        .tick(tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            duty   <= '0;
            goal_q <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (enter_stop) begin
                state  <= SOFT_STOP;
                goal_q <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (accept) begin
                            goal_q <= target;
                            if (target > duty) begin
                                state <= RAMP_UP;
                            end else if (target < duty) begin
                                state <= RAMP_DOWN;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    RAMP_UP: begin
                        if (tick) begin
                            duty <= duty_inc;
                            if (duty_inc == goal_q) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    RAMP_DOWN, SOFT_STOP: begin
                        if (tick) begin
                            duty <= duty_dec;
                            if (duty_dec == goal_q) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
        (state == RAMP_UP && tick && !enter_stop) |-> (duty != DUTY_MAX));

    a_no_underflow : assert property (@(posedge clk) disable iff (!rst)
        ((state == RAMP_DOWN || state == SOFT_STOP) && tick && !enter_stop)
            |-> (duty != '0));

endmodule
